lsu_stage: RTL and testbench

- Memory stage directly downstream of the execute ALU.
- Consumes the ALU result, either as a load/store address or as a pass-through value, and drives a single-port data-memory req/gnt/rvalid interface.
- Produces one registered writeback record per accepted instruction.
- Aligns store data to byte lanes, and extracts and sign/zero-extends load data. Flags misaligned accesses instead of issuing them.

---
 rtl/rv32_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 100 ++++++++++
 rtl/lsu_stage.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the load/store stage: funct3 access-size encodings,
// the LSU state enum, the byte-enable width and a helper that maps funct3 to
// an access size. Reserved encodings map to word accesses.
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Stores only define B/H/W. Loads also define BU/HU. Anything else is a word.
    function automatic lsu_size_t access_size(input logic [2:0] funct3,
                                              input logic       is_store);
        lsu_size_t size;
        if (is_store) begin
            case (funct3)
                F3_B:    size = SZ_B;
                F3_H:    size = SZ_H;
                default: size = SZ_W;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: size = SZ_B;
                F3_H, F3_HU: size = SZ_H;
                default:     size = SZ_W;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store stage.
// Store side: byte-enable generation, store-data lane replication and the
//             misalignment check for the incoming instruction.
// Load side:  lane extraction and sign/zero extension of the returned word,
//             using the offset and funct3 captured when the load was accepted.
// Ports:
//   st_addr_lo  [1:0]  byte offset of the incoming access
//   st_funct3   [2:0]  funct3 of the incoming access
//   st_is_store        incoming access is a store (loads take priority)
//   st_data     [31:0] raw rs2 store value
//   be          [3:0]  byte enables
//   wdata       [31:0] lane-replicated store data
//   misaligned         access crosses its natural alignment
//   ld_addr_lo  [1:0]  byte offset of the outstanding load
//   ld_funct3   [2:0]  funct3 of the outstanding load
//   rdata       [31:0] memory read word
//   ld_data     [31:0] extracted and extended load value
// -----------------------------------------------------------------------------
module lsu_align
    import rv32_pkg::*;
(
    input  logic [1:0]          st_addr_lo,
    input  logic [2:0]          st_funct3,
    input  logic                st_is_store,
    input  logic [31:0]         st_data,
    output logic [BE_WIDTH-1:0] be,
    output logic [31:0]         wdata,
    output logic                misaligned,
    input  logic [1:0]          ld_addr_lo,
    input  logic [2:0]          ld_funct3,
    input  logic [31:0]         rdata,
    output logic [31:0]         ld_data
);

    lsu_size_t   st_size_s;
    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    assign st_size_s = access_size(st_funct3, st_is_store);

    // Byte enables, replicated store data and alignment check for the incoming access
    always_comb begin
        be         = 4'b0000;
        wdata      = st_data;
        misaligned = 1'b0;
        case (st_size_s)
            SZ_B: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                be         = 4'b0011 << st_addr_lo;
                wdata      = {2{st_data[15:0]}};
                misaligned = st_addr_lo[0];
            end
            SZ_W: begin
                be         = 4'b1111;
                wdata      = st_data;
                misaligned = (st_addr_lo != 2'b00);
            end
            default: begin
                be         = 4'b1111;
                wdata      = st_data;
                misaligned = (st_addr_lo != 2'b00);
            end
        endcase
    end

    // Lane select from the returned word
    always_comb begin
        ld_byte_s = rdata[7:0];
        case (ld_addr_lo)
            2'd0:    ld_byte_s = rdata[7:0];
            2'd1:    ld_byte_s = rdata[15:8];
            2'd2:    ld_byte_s = rdata[23:16];
            2'd3:    ld_byte_s = rdata[31:24];
            default: ld_byte_s = rdata[7:0];
        endcase
        if (ld_addr_lo[1]) begin
            ld_half_s = rdata[31:16];
        end else begin
            ld_half_s = rdata[15:0];
        end
    end

    // Sign/zero extension by funct3; reserved encodings return the full word
    always_comb begin
        ld_data = rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_BU:   ld_data = {24'h000000, ld_byte_s};
            F3_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_HU:   ld_data = {16'h0000, ld_half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// -----------------------------------------------------------------------------
// lsu_stage
// Memory stage after the execute ALU. Non-memory ops pass the ALU result
// straight to writeback; legal loads/stores are issued on a single-port
// req/gnt/rvalid memory interface; misaligned accesses are flagged and never
// issued. Exactly one registered writeback pulse per accepted instruction.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid / in_ready              handshake from execute (ready only in IDLE)
//   in_is_load, in_is_store          op type (load wins if both set)
//   in_funct3, in_addr               access size/sign, ALU result
//   in_store_data, in_rd             rs2 value, destination register
//   dmem_req/we/addr/wdata/be        memory request, held until dmem_gnt
//   dmem_gnt, dmem_rvalid, dmem_rdata  memory grant and read return
//   wb_valid/rd/data/we              writeback record
//   misaligned                       qualifies wb_valid for rejected accesses
// -----------------------------------------------------------------------------
module lsu_stage
    import rv32_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_store_data,
    input  logic [RD_WIDTH-1:0]   in_rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [BE_WIDTH-1:0]   dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  wb_valid,
    output logic [RD_WIDTH-1:0]   wb_rd,
    output logic [31:0]           wb_data,
    output logic                  wb_we,
    output logic                  misaligned
);

    lsu_state_t            state_r;
    lsu_state_t            next_state_s;
    logic                  accept_s;
    logic                  is_mem_s;
    logic                  eff_store_s;
    logic                  mis_s;
    logic [BE_WIDTH-1:0]   be_s;
    logic [31:0]           wdata_s;
    logic [31:0]           ld_data_s;
    logic [31:0]           addr_word_s;
    logic [1:0]            addr_lo_r;
    logic [2:0]            funct3_r;
    logic                  is_store_r;
    logic [RD_WIDTH-1:0]   rd_r;

    assign in_ready    = (state_r == IDLE);
    assign accept_s    = in_valid & in_ready;
    assign is_mem_s    = in_is_load | in_is_store;
    assign eff_store_s = in_is_store & ~in_is_load;
    assign addr_word_s = 32'(in_addr);

    lsu_align u_align (
        .st_addr_lo  (in_addr[1:0]),
        .st_funct3   (in_funct3),
        .st_is_store (eff_store_s),
        .st_data     (in_store_data),
        .be          (be_s),
        .wdata       (wdata_s),
        .misaligned  (mis_s),
        .ld_addr_lo  (addr_lo_r),
        .ld_funct3   (funct3_r),
        .rdata       (dmem_rdata),
        .ld_data     (ld_data_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; gnt/rvalid only matter in their own states
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_mem_s && !mis_s) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (is_store_r) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = RESP;
                    end
                end else begin
                    next_state_s = REQ;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Fields of the issued access needed after it leaves IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_r  <= 2'b00;
            funct3_r   <= 3'b000;
            is_store_r <= 1'b0;
            rd_r       <= {RD_WIDTH{1'b0}};
        end else if (accept_s) begin
            addr_lo_r  <= in_addr[1:0];
            funct3_r   <= in_funct3;
            is_store_r <= eff_store_s;
            rd_r       <= in_rd;
        end
    end

    // Registered memory request and writeback record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {ADDR_WIDTH{1'b0}};
            dmem_wdata <= 32'h0000_0000;
            dmem_be    <= 4'b0000;
            wb_valid   <= 1'b0;
            wb_rd      <= {RD_WIDTH{1'b0}};
            wb_data    <= 32'h0000_0000;
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            // Writeback strobes are single-cycle pulses
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            misaligned <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (!is_mem_s) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b1;
                            wb_rd    <= in_rd;
                            wb_data  <= addr_word_s;
                        end else if (mis_s) begin
                            wb_valid   <= 1'b1;
                            misaligned <= 1'b1;
                            wb_rd      <= in_rd;
                            wb_data    <= addr_word_s;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= eff_store_s;
                            dmem_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                            dmem_be    <= be_s;
                            dmem_wdata <= wdata_s;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (is_store_r) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_r;
                            wb_data  <= 32'h0000_0000;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_rd    <= rd_r;
                        wb_data  <= ld_data_s;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_store_data;
    logic [4:0]  in_rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_we, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        mis;
        logic        chk_data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_stage #(.ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_we(wb_we), .misaligned(misaligned)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every writeback pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%08h, expected no writeback", wb_rd, wb_data);
            end else begin
                mon_e = sb.pop_front();
                check("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                check("wb_we", 32'(wb_we), 32'(mon_e.we));
                check("wb_misaligned", 32'(misaligned), 32'(mon_e.mis));
                if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
            end
        end
    end

    // Present one instruction; optionally push its expected writeback at offset lat
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input logic push, input logic [31:0] exp_data, input logic exp_we,
                         input logic exp_mis, input logic chk_data, input int lat);
        exp_t e;
        int w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        if (push) begin
            e.rd = rd; e.data = exp_data; e.we = exp_we; e.mis = exp_mis;
            e.chk_data = chk_data; e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_store_data = sd; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    // Full memory transaction with gw cycles of withheld grant and rw cycles before rvalid
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input int gw, input int rw, input logic spur,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
        logic is_st;
        is_st = st & ~ld;
        issue(ld, st, f3, addr, sd, rd, 1'b1, exp_data, ~is_st, 1'b0, ~is_st,
              is_st ? (1 + gw) : (2 + gw + rw));
        for (int i = 0; i <= gw; i++) begin
            if (i == gw) begin
                dmem_gnt = 1'b1;
                if (spur) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = 32'hDEAD_0000;
                end
            end
            check({tag, "_req"}, 32'(dmem_req), 32'd1);
            check({tag, "_we"}, 32'(dmem_we), 32'(is_st));
            check({tag, "_addr"}, dmem_addr, exp_addr);
            if (is_st) begin
                check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
                check({tag, "_wdata"}, dmem_wdata, exp_wdata);
            end
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (!is_st) begin
            check({tag, "_req_dropped"}, 32'(dmem_req), 32'd0);
            for (int i = 0; i < rw; i++) begin
                @(posedge clk); #1;
            end
            dmem_rvalid = 1'b1; dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        end
        check({tag, "_ready_with_wb"}, {30'd0, in_ready, wb_valid}, 32'd3);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'b000; in_addr = 32'h0; in_store_data = 32'h0; in_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {27'd0, dmem_req, dmem_we, wb_valid, wb_we, misaligned}, 32'd0);
        check("reset_data", dmem_addr | dmem_wdata | wb_data | 32'(dmem_be) | 32'(wb_rd), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-memory pass-through
        issue(1'b0, 1'b0, F3_W, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 0);
        check("nonmem_no_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;

        // Stores
        mem_op("sb", 1'b0, 1'b1, F3_B, 32'h0000_0103, 32'h0000_00A5, 5'd1, 3, 0, 1'b0,
               32'h0, 32'h0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        mem_op("sh", 1'b0, 1'b1, F3_H, 32'h0000_0102, 32'h1234_ABCD, 5'd2, 0, 0, 1'b0,
               32'h0, 32'h0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
        mem_op("sw", 1'b0, 1'b1, F3_W, 32'h0000_0200, 32'hDEAD_BEEF, 5'd3, 1, 0, 1'b0,
               32'h0, 32'h0, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF);

        // Loads from 0x80FF_7F01
        mem_op("lb", 1'b1, 1'b0, F3_B, 32'h0000_0002, 32'h0, 5'd10, 0, 0, 1'b0,
               32'h80FF_7F01, 32'hFFFF_FFFF, 32'h0, 4'h0, 32'h0);
        mem_op("lbu", 1'b1, 1'b0, F3_BU, 32'h0000_0003, 32'h0, 5'd11, 1, 1, 1'b0,
               32'h80FF_7F01, 32'h0000_0080, 32'h0, 4'h0, 32'h0);
        mem_op("lh", 1'b1, 1'b0, F3_H, 32'h0000_0002, 32'h0, 5'd12, 0, 0, 1'b0,
               32'h80FF_7F01, 32'hFFFF_80FF, 32'h0, 4'h0, 32'h0);
        mem_op("lhu", 1'b1, 1'b0, F3_HU, 32'h0000_0000, 32'h0, 5'd13, 0, 2, 1'b0,
               32'h80FF_7F01, 32'h0000_7F01, 32'h0, 4'h0, 32'h0);
        // Both load and store set: behaves as a load
        mem_op("lw_both", 1'b1, 1'b1, F3_W, 32'h0000_0104, 32'h5555_5555, 5'd14, 0, 0, 1'b0,
               32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0104, 4'h0, 32'h0);
        // Reserved load funct3 is a word access
        mem_op("l_rsvd", 1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0, 5'd15, 0, 0, 1'b0,
               32'h0246_8ACE, 32'h0246_8ACE, 32'h0000_0008, 4'h0, 32'h0);
        // Spurious rvalid in the grant cycle is ignored
        mem_op("spur", 1'b1, 1'b0, F3_W, 32'h0000_0020, 32'h0, 5'd16, 0, 1, 1'b1,
               32'h1357_9BDF, 32'h1357_9BDF, 32'h0000_0020, 4'h0, 32'h0);

        // Misaligned accesses are flagged, never issued
        issue(1'b1, 1'b0, F3_W, 32'h0000_0106, 32'h0, 5'd7, 1'b1, 32'h0000_0106, 1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            check("mis_lw_no_req", 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
        end
        issue(1'b0, 1'b1, F3_H, 32'h0000_0101, 32'h0, 5'd8, 1'b1, 32'h0000_0101, 1'b0, 1'b1, 1'b1, 0);
        check("mis_sh_no_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;

        // Reset while in RESP drops the load
        issue(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_resp_ctrl", {27'd0, dmem_req, dmem_we, wb_valid, wb_we, misaligned}, 32'd0);
        check("rst_resp_addr", dmem_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_resp_no_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end

        issue(1'b0, 1'b0, F3_B, 32'h0000_CAFE, 32'h0, 5'd31, 1'b1, 32'h0000_CAFE, 1'b1, 1'b0, 1'b1, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
